// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shared memory port sequencer for fetch and data requesters; MEM_ARB_RR_EN selects round-robin tie-break
module mem_arbiter #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        m_en,
    output logic        m_we,
    output logic [3:0]  m_be,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_rvalid,
    input  logic [31:0] m_rdata,
    output logic        err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t            state, state_nx;
    logic              owner_d;     // 1 = data requester owns the transaction
    logic              last_grant;  // 1 = data
    logic              grant_d;
    logic              any_req;
    logic              timeout_hit;
    logic [CNT_W-1:0]  cnt;
    logic              lat_we;
    logic [3:0]        lat_be;
    logic [31:0]       lat_addr;
    logic [31:0]       lat_wdata;
    logic [31:0]       i_rdata_q;
    logic [31:0]       d_rdata_q;
    logic              err_q;

    assign any_req     = i_req | d_req;
    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

`ifdef MEM_ARB_RR_EN
    assign grant_d = (i_req && d_req) ? ~last_grant :
                     d_req            ? 1'b1 :
                     i_req            ? 1'b0 : last_grant;
`else
    assign grant_d = d_req ? 1'b1 : (i_req ? 1'b0 : last_grant);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (any_req) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (m_rvalid || timeout_hit) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_d    <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
            lat_we     <= 1'b0;
            lat_be     <= 4'h0;
            lat_addr   <= 32'h0;
            lat_wdata  <= 32'h0;
            i_rdata_q  <= 32'h0;
            d_rdata_q  <= 32'h0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner_d    <= grant_d;
                        last_grant <= grant_d;
                        if (grant_d) begin
                            lat_we    <= d_we;
                            lat_be    <= d_be;
                            lat_addr  <= d_addr;
                            lat_wdata <= d_wdata;
                        end else begin
                            lat_we    <= 1'b0;
                            lat_be    <= 4'b1111;
                            lat_addr  <= i_addr;
                            lat_wdata <= 32'h0;
                        end
                    end
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    // m_rvalid outranks a watchdog expiry in the same cycle
                    if (m_rvalid) begin
                        if (owner_d) d_rdata_q <= m_rdata;
                        else         i_rdata_q <= m_rdata;
                    end else if (timeout_hit) begin
                        if (owner_d) d_rdata_q <= 32'hDEAD_BEEF;
                        else         i_rdata_q <= 32'hDEAD_BEEF;
                        err_q <= 1'b1;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_en    = (state == ISSUE);
    assign i_ack   = (state == DONE) && !owner_d;
    assign d_ack   = (state == DONE) &&  owner_d;
    assign m_we    = lat_we;
    assign m_be    = lat_be;
    assign m_addr  = lat_addr;
    assign m_wdata = lat_wdata;
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;
    assign err     = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a delay-programmable memory model
module tb_mem_arbiter;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    typedef struct {
        logic        is_data;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        m_en;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_rvalid;
    logic [31:0] m_rdata;
    logic        err;

    exp_t        sb[$];
    exp_t        e;
    int          vectors = 0;
    int          miscompares = 0;

    int          mem_delay;   // cycles from m_en to m_rvalid; 0 = never respond
    int          cd;
    logic        fixed_en;
    logic [31:0] fixed_data;
    logic [31:0] cur_addr;
    int          en_cnt;
    logic        en_we;
    logic [3:0]  en_be;
    logic [31:0] en_addr;
    logic [31:0] en_wdata;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .m_en(m_en), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .err(err)
    );

    task automatic step();
        @(negedge clk);
        m_rvalid = 1'b0;
        if (!rst) begin
            cd = 0;
        end else begin
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    m_rvalid = 1'b1;
                    m_rdata  = fixed_en ? fixed_data : (cur_addr ^ KEY);
                end
            end
            if (m_en) begin
                en_cnt++;
                en_we    = m_we;
                en_be    = m_be;
                en_addr  = m_addr;
                en_wdata = m_wdata;
                cur_addr = m_addr;
                if (mem_delay > 0) cd = mem_delay;
            end
        end
    endtask

    task automatic wait_ack(output int cyc);
        logic seen;
        seen = 1'b0;
        cyc  = -1;
        for (int c = 1; c <= 60 && !seen; c++) begin
            step();
            if (i_ack || d_ack) begin
                seen = 1'b1;
                cyc  = c;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_be = 0; d_addr = 0; d_wdata = 0;
        m_rvalid = 0; m_rdata = 0; mem_delay = 0; cd = 0; fixed_en = 0; fixed_data = 0;
        cur_addr = 0; en_cnt = 0; en_we = 0; en_be = 0; en_addr = 0; en_wdata = 0;
        step();
        step();
        vectors++;
        if ({i_ack, d_ack, m_en, m_we, m_be, err} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 0", {i_ack, d_ack, m_en, m_we, m_be, err});
        end
        vectors++;
        if ({m_addr, m_wdata, i_rdata, d_rdata} !== 128'h0) begin
            miscompares++;
            $display("FAIL reset_data: got %h/%h/%h/%h want 0", m_addr, m_wdata, i_rdata, d_rdata);
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_single_fetch();
        int c, en0;
        en0 = en_cnt;
        fixed_en = 1'b1; fixed_data = 32'h2408_0005;
        mem_delay = 2;
        i_req = 1'b1; i_addr = 32'h0000_3000;
        sb.push_back('{1'b0, 32'h2408_0005});
        wait_ack(c);
        i_req = 1'b0;
        fixed_en = 1'b0;
        vectors++;
        if (c !== 4) begin
            miscompares++;
            $display("FAIL fetch_latency: got %0d want 4", c);
        end
        vectors++;
        if ({en_we, en_be, en_addr} !== {1'b0, 4'hF, 32'h0000_3000} || en_cnt - en0 !== 1) begin
            miscompares++;
            $display("FAIL fetch_issue: we=%b be=%h addr=%h pulses=%0d want 0/f/00003000/1",
                     en_we, en_be, en_addr, en_cnt - en0);
        end
        e = sb.pop_front();
        vectors++;
        if (d_ack !== e.is_data || i_ack !== !e.is_data || i_rdata !== e.data) begin
            miscompares++;
            $display("FAIL fetch_ack: i_ack=%b d_ack=%b i_rdata=%h want 1/0/%h", i_ack, d_ack, i_rdata, e.data);
        end
        step();
    endtask

    task automatic test_store();
        int c, en0;
        en0 = en_cnt;
        mem_delay = 3;
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0100;
        d_addr = 32'h0000_0012; d_wdata = 32'h00AB_0000;
        sb.push_back('{1'b1, 32'h0000_0012 ^ KEY});
        wait_ack(c);
        d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
        vectors++;
        if ({en_we, en_be, en_addr, en_wdata} !== {1'b1, 4'b0100, 32'h0000_0012, 32'h00AB_0000}) begin
            miscompares++;
            $display("FAIL store_issue: we=%b be=%h addr=%h wdata=%h", en_we, en_be, en_addr, en_wdata);
        end
        vectors++;
        if (m_addr !== 32'h0000_0012 || c !== 5 || en_cnt - en0 !== 1) begin
            miscompares++;
            $display("FAIL store_hold: m_addr=%h lat=%0d pulses=%0d want 00000012/5/1", m_addr, c, en_cnt - en0);
        end
        e = sb.pop_front();
        vectors++;
        if (d_ack !== e.is_data || i_ack !== 1'b0 || d_rdata !== e.data) begin
            miscompares++;
            $display("FAIL store_ack: d_ack=%b i_ack=%b d_rdata=%h want 1/0/%h", d_ack, i_ack, d_rdata, e.data);
        end
        step();
        vectors++;
        if (d_ack !== 1'b0) begin
            miscompares++;
            $display("FAIL store_single_pulse: d_ack=%b want 0", d_ack);
        end
    endtask

    task automatic test_collision(input logic first_is_data);
        int c1, c2;
        mem_delay = 1;
        i_req = 1'b1; i_addr = 32'h0000_0200;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300;
        if (first_is_data) begin
            sb.push_back('{1'b1, 32'h0000_0300 ^ KEY});
            sb.push_back('{1'b0, 32'h0000_0200 ^ KEY});
        end else begin
            sb.push_back('{1'b0, 32'h0000_0200 ^ KEY});
            sb.push_back('{1'b1, 32'h0000_0300 ^ KEY});
        end
        for (int k = 0; k < 2; k++) begin
            wait_ack(c1);
            e = sb.pop_front();
            vectors++;
            if (d_ack !== e.is_data || i_ack !== !e.is_data ||
                (e.is_data ? d_rdata : i_rdata) !== e.data) begin
                miscompares++;
                $display("FAIL collision_%0d: i_ack=%b d_ack=%b i_rdata=%h d_rdata=%h want data=%b %h",
                         k, i_ack, d_ack, i_rdata, d_rdata, e.is_data, e.data);
            end
            if (d_ack) d_req = 1'b0;
            if (i_ack) i_req = 1'b0;
            if (k == 0) c2 = c1;
        end
        vectors++;
        if (c2 !== 3 || c1 !== 4) begin
            miscompares++;
            $display("FAIL collision_timing: got %0d,%0d want 3,4", c2, c1);
        end
        i_req = 1'b0; d_req = 1'b0;
        step();
    endtask

    task automatic test_timeout_race();
        int c;
        mem_delay = 16;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0440;
        sb.push_back('{1'b1, 32'h0000_0440 ^ KEY});
        wait_ack(c);
        d_req = 1'b0;
        e = sb.pop_front();
        vectors++;
        if (c !== 18 || d_ack !== e.is_data || d_rdata !== e.data || err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_race: lat=%0d d_ack=%b d_rdata=%h err=%b want 18/1/%h/0",
                     c, d_ack, d_rdata, err, e.data);
        end
        step();
    endtask

    task automatic test_watchdog();
        int c;
        mem_delay = 0;
        i_req = 1'b1; i_addr = 32'h0000_0500;
        sb.push_back('{1'b0, 32'hDEAD_BEEF});
        wait_ack(c);
        i_req = 1'b0;
        e = sb.pop_front();
        vectors++;
        if (c !== 18 || i_ack !== !e.is_data || i_rdata !== e.data || err !== 1'b1) begin
            miscompares++;
            $display("FAIL watchdog: lat=%0d i_ack=%b i_rdata=%h err=%b want 18/1/%h/1",
                     c, i_ack, i_rdata, err, e.data);
        end
        step();
        mem_delay = 2;
        i_req = 1'b1; i_addr = 32'h0000_0600;
        sb.push_back('{1'b0, 32'h0000_0600 ^ KEY});
        wait_ack(c);
        i_req = 1'b0;
        e = sb.pop_front();
        vectors++;
        if (c !== 4 || i_rdata !== e.data || err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_sticky: lat=%0d i_rdata=%h err=%b want 4/%h/1", c, i_rdata, err, e.data);
        end
        step();
    endtask

    task automatic test_reset_mid_wait();
        int c;
        logic stray;
        mem_delay = 0;
        i_req = 1'b1; i_addr = 32'h0000_0700;
        for (int k = 0; k < 4; k++) step();
        rst = 1'b0;
        #1;
        vectors++;
        if ({i_ack, d_ack, m_en, err} !== 4'h0 || m_addr !== 32'h0 || i_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mid_wait: acks=%b%b m_en=%b err=%b m_addr=%h i_rdata=%h want 0",
                     i_ack, d_ack, m_en, err, m_addr, i_rdata);
        end
        sb.delete();
        i_req = 1'b0;
        stray = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (i_ack || d_ack || m_en) stray = 1'b1;
        end
        rst = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (i_ack || d_ack || m_en) stray = 1'b1;
        end
        vectors++;
        if (stray !== 1'b0) begin
            miscompares++;
            $display("FAIL abandoned_txn: stray activity=%b want 0", stray);
        end
        mem_delay = 2;
        i_req = 1'b1; i_addr = 32'h0000_0040;
        sb.push_back('{1'b0, 32'h0000_0040 ^ KEY});
        wait_ack(c);
        i_req = 1'b0;
        e = sb.pop_front();
        vectors++;
        if (c !== 4 || i_ack !== 1'b1 || i_rdata !== e.data || err !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_fetch: lat=%0d i_ack=%b i_rdata=%h err=%b want 4/1/%h/0",
                     c, i_ack, i_rdata, err, e.data);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_store();
`ifdef MEM_ARB_RR_EN
        test_collision(1'b0);
`else
        test_collision(1'b1);
`endif
        test_single_fetch();
        test_collision(1'b1);
        test_timeout_race();
        test_watchdog();
        test_reset_mid_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences a single shared memory port between the instruction-fetch requester (IR load) and the data requester (load/store, byte enables from the byte-enable generator) of the multicycle MIPS core.
- Arbitrates between the two requesters and issues one memory transaction at a time.
- Waits a variable number of cycles for the memory response.
- Returns read data with a one-cycle acknowledge. A watchdog recovers from a memory that never responds.

Parameters:
- TIMEOUT, 16, maximum cycles spent in WAIT before forced error completion; 0 disables the watchdog.
- CNT_W, 5, width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- i_req  in  1  instruction fetch request; held until i_ack.
- i_addr  in  32  fetch byte address (PC).
- i_ack  out  1  one-cycle completion pulse, fetch.
- i_rdata  out  32  fetched word; valid while i_ack=1, held until the next completion.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1=store, 0=load.
- d_be  in  4  byte enables for the store.
- d_addr  in  32  data byte address (ALUOut).
- d_wdata  in  32  store data (register B).
- d_ack  out  1  one-cycle completion pulse, data.
- d_rdata  out  32  load word (raw; byte/half extraction is downstream); held until the next completion.
- m_en  out  1  one-cycle transaction strobe to memory.
- m_we  out  1  write enable, qualified by m_en.
- m_be  out  4  byte enables, qualified by m_en.
- m_addr  out  32  address, held stable from ISSUE through DONE.
- m_wdata  out  32  write data, held stable from ISSUE through DONE.
- m_rvalid  in  1  memory completion; read data is valid on m_rdata in the same cycle.
- m_rdata  in  32  memory read data.
- err  out  1  sticky flag, set on watchdog expiry, cleared only by reset.

Behaviour:
- Clock and reset: one clock (clk); reset rst is asynchronous and active-low.
- Reset values:
  - All outputs 0.
  - state=IDLE, watchdog counter=0, last_grant=DATA.
- Reset asserted mid-transaction:
  - Returns to IDLE immediately; m_en and both acks drop.
  - The in-flight transaction is abandoned with no ack.
  - Requesters re-request after reset.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req is high at the clock edge, latch the owner, address, we, be and wdata into internal registers, then go to ISSUE.
  - Instruction grant forces m_we=0 and m_be=4'b1111.
- Arbitration:
  - Default: fixed priority, data wins over instruction when both requests are high in the same cycle. Data always belongs to the instruction already in flight.
  - Record last_grant on every grant.
- ISSUE:
  - m_en=1 for exactly this cycle, with m_we, m_be, m_addr and m_wdata from the latched registers.
  - Go to WAIT, clearing the counter.
- WAIT:
  - m_rvalid is sampled only in this state and ignored in all others.
  - On m_rvalid=1: capture m_rdata into the owner's rdata register, go to DONE.
  - Otherwise increment the counter.
  - If TIMEOUT≠0 and counter reaches TIMEOUT-1 without m_rvalid: load 32'hDEAD_BEEF into the owner's rdata, set err, go to DONE.
  - A simultaneous m_rvalid and timeout: m_rvalid wins and err is not set.
- DONE:
  - Owner's ack=1 for one cycle, then go to IDLE.
  - The requester must drop req on the edge ending DONE.
  - IDLE does not sample during DONE, so the same request is never granted twice.
- Latency: a request first seen in IDLE in cycle 0 gives m_en in cycle 1, WAIT from cycle 2, and ack in cycle k+1 where k is the cycle m_rvalid is asserted (minimum ack at cycle 3).
- Throughput: back-to-back requests leave one IDLE cycle between transactions.
- Store completions also update d_rdata with m_rdata; the value is don't-care to the core.
- Requester inputs are not re-sampled after the grant. Changes during a transaction are ignored.
- Counter saturates and never wraps.

Optional Feature:
- Macro MEM_ARB_RR_EN.
- Defined: round-robin on simultaneous requests; the requester not in last_grant wins. last_grant=DATA at reset, so the first tie goes to instruction.
- Not defined: fixed data-over-instruction priority as above. last_grant is still maintained but unused.

Test Plan:
- Single fetch: i_req=1, i_addr=0x0000_3000, memory returns m_rvalid with m_rdata=0x2408_0005 two cycles after m_en -> m_en=1, m_we=0, m_be=4'hF in cycle 1; i_ack=1 in cycle 4 with i_rdata=0x2408_0005; d_ack stays 0.
- Store byte: d_req=1, d_we=1, d_be=4'b0100, d_addr=0x0000_0012, d_wdata=0x00AB_0000 -> m_en pulse carries exactly these values, m_addr holds until DONE; d_ack pulses once.
- Collision: i_req and d_req both rise in the same cycle -> default build: data granted first, fetch next; with MEM_ARB_RR_EN: fetch first, and a second collision grants data.
- Watchdog: TIMEOUT=16, m_rvalid never asserted -> ack in the cycle after the 16th WAIT cycle with rdata=0xDEAD_BEEF, err=1 and sticky through later successful transactions.
- Timeout race: m_rvalid asserted in the last WAIT cycle -> normal data returned, err remains 0.
- Reset mid-WAIT: rst low during WAIT -> outputs 0 immediately, no ack; after release, a new i_req completes normally.
